// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and width defaults for the MAR/MDR memory access stage
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } mem_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-addressed RAM req/ready bus between access unit and memory
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_handshake_fsm.sv
// rtl/mem_handshake_fsm.sv - req/ready handshake sequencer with state-decoded Moore outputs
module mem_handshake_fsm
    import mem_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic read_i,
    input  logic write_i,
    input  logic mem_ready_i,
    output logic mem_req_o,
    output logic mem_we_o,
    output logic busy_o,
    output logic done_o,
    output logic idle_o,
    output logic mdr_load_mem_o
);

    mem_state_e state_q;
    mem_state_e state_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read wins over a simultaneous Write; requests are only taken from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = READ;
                end else if (write_i) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        idle_o    = 1'b0;
        case (state_q)
            IDLE: begin
                idle_o = 1'b1;
            end
            READ: begin
                mem_req_o = 1'b1;
                busy_o    = 1'b1;
            end
            WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                busy_o    = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
                idle_o = 1'b0;
            end
        endcase
    end

    assign mdr_load_mem_o = (state_q == READ) && mem_ready_i;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MAR/MDR datapath stage driving a multi-cycle RAM through the handshake FSM
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic [DATA_WIDTH-1:0] MDRout_data,
    output logic                  busy,
    output logic                  done,
    mem_access_unit_if.master     mem
);

    logic [ADDR_WIDTH-1:0] mar_q;
    logic [ADDR_WIDTH-1:0] mar_d;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] mdr_d;

    logic idle;
    logic mdr_load_mem;
    logic fsm_req;
    logic fsm_we;

    mem_handshake_fsm u_fsm (
        .clk_i          (clock),
        .rst_i          (clear),
        .read_i         (Read),
        .write_i        (Write),
        .mem_ready_i    (mem.mem_ready),
        .mem_req_o      (fsm_req),
        .mem_we_o       (fsm_we),
        .busy_o         (busy),
        .done_o         (done),
        .idle_o         (idle),
        .mdr_load_mem_o (mdr_load_mem)
    );

    // Bus loads are only honoured in IDLE so address and write data hold for the whole request.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (idle && MARin) begin
            mar_d = BusMuxOut[ADDR_WIDTH-1:0];
        end
        if (mdr_load_mem) begin
            mdr_d = mem.mem_rdata;
        end else if (idle && MDRin) begin
            mdr_d = BusMuxOut;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    assign mem.mem_req   = fsm_req;
    assign mem.mem_we    = fsm_we;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;
    assign MDRout_data   = mdr_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Combined MAR/MDR memory-interface stage on the datapath bus; the bus feeds R0 and the other general registers.
- MAR latches an address from the bus.
- MDR latches data from either the bus or memory.
- A small FSM runs a req/ready handshake with a word-addressed RAM so that multi-cycle memory works under the control unit's Read/Write strobes. The MDR value is driven to the bus mux, from which it reaches the register inputs.

Parameters:
DATA_WIDTH, 32, width of data bus, MDR and memory data
ADDR_WIDTH, 9, width of MAR and memory address (512 words)

Ports:
clock  input  1  system clock, rising-edge
clear  input  1  reset, asynchronous, active-high
MARin  input  1  load MAR from BusMuxOut[ADDR_WIDTH-1:0]
MDRin  input  1  load MDR from BusMuxOut (when no read completes)
Read  input  1  start memory read at address MAR
Write  input  1  start memory write of MDR to address MAR
BusMuxOut  input  DATA_WIDTH  datapath bus value
mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ready=1 during a read
mem_ready  input  1  memory completion for current request
mem_req  output  1  memory request active
mem_we  output  1  1 = write request, 0 = read request
mem_addr  output  ADDR_WIDTH  current MAR
mem_wdata  output  DATA_WIDTH  current MDR
MDRout_data  output  DATA_WIDTH  MDR contents to bus mux
busy  output  1  transaction in progress
done  output  1  one-cycle pulse after a transaction completes

Behaviour:
- Reset: clear is asynchronous, active-high. On assertion, the following go to 0 immediately regardless of clock:
  - MAR and MDR
  - mem_req, mem_we, busy, done
  - state, which goes to IDLE
- Reset mid-transaction: the transaction is abandoned and mem_req drops the same instant. Any later mem_ready is ignored.
- Outputs with fixed mappings:
  - mem_addr = MAR and mem_wdata = MDR, continuously.
  - MDRout_data = MDR, continuously (bus selection is done in the bus mux).
  - mem_req, mem_we, busy and done are decoded from state only; they are Moore outputs with no combinational path from inputs.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Read=1 goes to READ.
  - Write=1 (with Read=0) goes to WRITE.
  - Read and Write both 1 goes to READ, and Write is dropped.
  - MARin and MDRin are honoured.
  - mem_ready is ignored.
- READ:
  - Outputs: mem_req=1, mem_we=0, busy=1.
  - On an edge with mem_ready=1: MDR <= mem_rdata and the FSM goes to DONE.
  - Otherwise the FSM stays in READ, waiting indefinitely (no timeout).
- WRITE:
  - Outputs: mem_req=1, mem_we=1, busy=1.
  - On an edge with mem_ready=1 the FSM goes to DONE. MDR is unchanged.
- DONE:
  - Outputs: done=1, busy=0, mem_req=0.
  - Exactly one cycle, then unconditionally back to IDLE.
  - Read and Write are ignored in DONE; the control unit issues a new request from IDLE.
- Requests in flight:
  - In READ, WRITE and DONE, MARin, MDRin, Read and Write are all ignored.
  - This keeps mem_addr and mem_wdata stable for the whole request.
- MDR write priority: read completion beats MDRin. Because MDRin is ignored while busy, the two can never conflict in practice.
- Minimum latency with a zero-wait memory:
  - Read sampled at edge 0 gives mem_req=1 after edge 0.
  - With mem_ready=1 at edge 1, MDR is updated at edge 1 and done=1 for the cycle after edge 1.
  - That is 2 cycles from request to done.
- Widths:
  - MAR takes the low ADDR_WIDTH bits of the bus; upper bus bits are discarded.
  - No sign extension, no arithmetic.

Decomposition:
- Shared package `mem_pkg` holds:
  - state enum (IDLE=2'b00, READ=2'b01, WRITE=2'b10, DONE=2'b11)
  - DATA_WIDTH and ADDR_WIDTH defaults
- One natural sub-module: `mem_handshake_fsm`.
  - Inputs: Read, Write, mem_ready.
  - Outputs: mem_req, mem_we, busy, done, and the MDR-from-memory load strobe.
  - The MAR and MDR registers stay in the top level.

Test Plan:
1. Reset: assert clear asynchronously between edges while in READ with mem_req=1 -> mem_req, busy, MAR and MDR read 0 before the next edge; a later mem_ready=1 produces no done.
2. Bus loads: BusMuxOut=32'h0000_0A5F with MARin=1 -> mem_addr=9'h05F. Then BusMuxOut=32'hDEAD_BEEF with MDRin=1 -> MDRout_data=32'hDEAD_BEEF.
3. Zero-wait read: MAR=9'h010, Read pulse, mem_ready=1 with mem_rdata=32'h1234_5678 -> mem_req high 1 cycle, MDR=32'h1234_5678, done high exactly 1 cycle, 2 cycles after Read.
4. Wait-state write: MDR=32'hCAFE_0001, MAR=9'h1FF, Write pulse, mem_ready low 3 cycles then high -> mem_req=1 and mem_we=1 for 4 cycles with stable addr/wdata; done pulses once; MDR unchanged.
5. Ignored inputs: during a READ stall, toggle MARin/MDRin with BusMuxOut=32'hFFFF_FFFF and pulse Write -> mem_addr and MDR unchanged, no WRITE follows; in IDLE, Read=Write=1 -> mem_we=0 (read only).
